// File: rtl/vga_char_mem_scroll.sv
// rtl/vga_char_mem_scroll.sv - character/colour memory with data port, scrolled VGA port and fill engine
//
// Purpose:
//   Single-clock cell memory for the VGA text display. One read/write data port
//   for the processor (per-byte write enables, read-first, 1-cycle latency), one
//   read-only VGA port whose row is offset by a hardware scroll register, and a
//   fill engine that writes one value to every cell (screen clear).
//   Cell layout for DATA_W=32: {bg[31:20], fg[19:8], ascii[7:0]}.
//
// Ports:
//   clk_i                 single clock for both ports and the fill engine
//   rst_i                 asynchronous active-high reset (memory contents untouched)
//   data_addr_i           physical cell address {row, col}
//   data_we_i             write strobe (dropped while the fill engine is busy)
//   data_be_i             byte-lane write enables
//   data_write_value_i    write data
//   data_read_value_o     registered read data (old word on same-cycle write)
//   vga_addr_i            logical {row, col} from the renderer
//   scroll_row_i          row offset added (mod ROWS) to the logical row
//   vga_read_value_o      registered read data for the renderer
//   fill_start_i          start a fill (accepted only when idle)
//   fill_value_i          value written to every cell
//   fill_busy_o           high while the fill engine owns the write port
//   fill_done_o           one-cycle pulse when a fill completes

module vga_char_mem_scroll #(
  parameter int COLS   = 128,
  parameter int ROWS   = 32,
  parameter int DATA_W = 32,
  localparam int COL_W  = $clog2(COLS),
  localparam int ROW_W  = $clog2(ROWS),
  localparam int NB     = DATA_W / 8,
  localparam int ADDR_W = ROW_W + COL_W,
  localparam int DEPTH  = COLS * ROWS
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic              data_we_i,
  input  logic [NB-1:0]     data_be_i,
  input  logic [DATA_W-1:0] data_write_value_i,
  output logic [DATA_W-1:0] data_read_value_o,
  input  logic [ADDR_W-1:0] vga_addr_i,
  input  logic [ROW_W-1:0]  scroll_row_i,
  output logic [DATA_W-1:0] vga_read_value_o,
  input  logic              fill_start_i,
  input  logic [DATA_W-1:0] fill_value_i,
  output logic              fill_busy_o,
  output logic              fill_done_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   fill_val_q, fill_val_d;

  logic [DATA_W-1:0]   data_rd_q;
  logic [DATA_W-1:0]   vga_rd_q;

  // Shared write port: either the fill engine or the processor drives it.
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [NB-1:0]       mem_wbe;
  logic [DATA_W-1:0]   mem_wdata;

  logic [ROW_W-1:0]    vga_row_phys;
  logic [ADDR_W-1:0]   vga_addr_phys;

  logic [DATA_W-1:0]   mem [DEPTH];

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      fill_val_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fill_val_q <= fill_val_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fill_val_d = fill_val_q;
    case (state_q)
      ST_IDLE: begin
        if (fill_start_i) begin
          state_d    = ST_FILL;
          cnt_d      = '0;
          fill_val_d = fill_value_i;
        end
      end
      ST_FILL: begin
        // Counter wraps at ADDR_W bits, so it never addresses past the array.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: status flags and write-port arbitration
  always_comb begin
    fill_busy_o = (state_q == ST_FILL);
    fill_done_o = (state_q == ST_DONE);
    if (state_q == ST_FILL) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wbe   = '1;
      mem_wdata = fill_val_q;
    end else begin
      mem_we    = data_we_i;
      mem_waddr = data_addr_i;
      mem_wbe   = data_be_i;
      mem_wdata = data_write_value_i;
    end
  end

  // Storage: no reset so the array maps onto block RAM with byte enables.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NB; i++) begin
      if (mem_we && mem_wbe[i]) begin
        mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // Scrolled physical row; the ROW_W-bit add wraps modulo ROWS.
  assign vga_row_phys  = vga_addr_i[ADDR_W-1:COL_W] + scroll_row_i;
  assign vga_addr_phys = {vga_row_phys, vga_addr_i[COL_W-1:0]};

  // Read registers. Non-blocking reads give read-first behaviour on both ports.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_rd_q <= '0;
      vga_rd_q  <= '0;
    end else begin
      if (state_q != ST_FILL) begin
        data_rd_q <= mem[data_addr_i];
      end
      vga_rd_q <= mem[vga_addr_phys];
    end
  end

  assign data_read_value_o = data_rd_q;
  assign vga_read_value_o  = vga_rd_q;

endmodule

// File: tb/tb_vga_char_mem_scroll.sv
// tb/tb_vga_char_mem_scroll.sv - directed self-checking bench for vga_char_mem_scroll
module tb_vga_char_mem_scroll;

  localparam int DEPTH  = 4096;
  localparam int DEPTH2 = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [11:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wv;
  logic [31:0] data_rv;
  logic [11:0] vga_addr;
  logic [4:0]  scroll;
  logic [31:0] vga_rv;
  logic        fill_start;
  logic [31:0] fill_value;
  logic        fill_busy;
  logic        fill_done;

  logic [9:0]  a2_addr;
  logic        a2_we;
  logic [1:0]  a2_be;
  logic [15:0] a2_wv;
  logic [15:0] a2_rv;
  logic [9:0]  a2_vaddr;
  logic [3:0]  a2_scroll;
  logic [15:0] a2_vrv;
  logic        a2_fs;
  logic [15:0] a2_fv;
  logic        a2_busy;
  logic        a2_done;

  vga_char_mem_scroll u_dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .data_addr_i        (data_addr),
    .data_we_i          (data_we),
    .data_be_i          (data_be),
    .data_write_value_i (data_wv),
    .data_read_value_o  (data_rv),
    .vga_addr_i         (vga_addr),
    .scroll_row_i       (scroll),
    .vga_read_value_o   (vga_rv),
    .fill_start_i       (fill_start),
    .fill_value_i       (fill_value),
    .fill_busy_o        (fill_busy),
    .fill_done_o        (fill_done)
  );

  vga_char_mem_scroll #(.COLS(64), .ROWS(16), .DATA_W(16)) u_dut2 (
    .clk_i              (clk),
    .rst_i              (rst),
    .data_addr_i        (a2_addr),
    .data_we_i          (a2_we),
    .data_be_i          (a2_be),
    .data_write_value_i (a2_wv),
    .data_read_value_o  (a2_rv),
    .vga_addr_i         (a2_vaddr),
    .scroll_row_i       (a2_scroll),
    .vga_read_value_o   (a2_vrv),
    .fill_start_i       (a2_fs),
    .fill_value_i       (a2_fv),
    .fill_busy_o        (a2_busy),
    .fill_done_o        (a2_done)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
    data_addr = a;
    data_wv   = d;
    data_be   = be;
    data_we   = 1'b1;
    tick();
    data_we   = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a);
    data_addr = a;
    tick();
  endtask

  int busy_cycles;
  int done_pulses;
  int done_edge;
  int bad;

  initial begin
    rst = 1'b1;
    data_addr = '0; data_we = 1'b0; data_be = '0; data_wv = '0;
    vga_addr = '0; scroll = '0; fill_start = 1'b0; fill_value = '0;
    a2_addr = '0; a2_we = 1'b0; a2_be = '0; a2_wv = '0;
    a2_vaddr = '0; a2_scroll = '0; a2_fs = 1'b0; a2_fv = '0;
    tick();
    tick();
    check("reset_data_rd", data_rv, 32'h0);
    check("reset_vga_rd", vga_rv, 32'h0);
    check("reset_busy", {31'b0, fill_busy}, 32'h0);
    check("reset_done", {31'b0, fill_done}, 32'h0);
    rst = 1'b0;
    tick();

    // Byte enables
    wr(12'd5, 32'h11223344, 4'b1111);
    wr(12'd5, 32'hAABBCCDD, 4'b0010);
    rd(12'd5);
    check("byte_enable", data_rv, 32'h1122CC44);
    wr(12'd5, 32'hFFFFFFFF, 4'b0000);
    rd(12'd5);
    check("be_zero_noop", data_rv, 32'h1122CC44);

    // Scroll
    wr(12'd3, 32'h00000041, 4'b1111);
    wr(12'd131, 32'h00000099, 4'b1111);
    vga_addr = 12'd131; scroll = 5'd31;
    tick();
    check("scroll31_row1", vga_rv, 32'h00000041);
    vga_addr = 12'd3; scroll = 5'd0;
    tick();
    check("scroll0_row0", vga_rv, 32'h00000041);
    vga_addr = 12'd131;
    tick();
    check("scroll0_row1", vga_rv, 32'h00000099);
    vga_addr = 12'd3971; scroll = 5'd2;
    tick();
    check("scroll_wrap_row31", vga_rv, 32'h00000099);

    // Collision and read-first
    wr(12'd7, 32'h00000007, 4'b1111);
    data_addr = 12'd7; data_wv = 32'hDEADBEEF; data_be = 4'b1111; data_we = 1'b1;
    vga_addr = 12'd7; scroll = 5'd0;
    tick();
    data_we = 1'b0;
    check("collision_vga_old", vga_rv, 32'h00000007);
    check("read_first_data", data_rv, 32'h00000007);
    tick();
    check("collision_vga_new", vga_rv, 32'hDEADBEEF);
    check("collision_data_new", data_rv, 32'hDEADBEEF);

    // Full fill
    fill_value = 32'h00F00020;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    fill_value = 32'h0BADF00D;
    busy_cycles = 0; done_pulses = 0; done_edge = -1;
    for (int e = 0; e < DEPTH + 6; e++) begin
      if (fill_busy) busy_cycles++;
      if (fill_done) begin
        done_pulses++;
        if (done_edge < 0) done_edge = e;
      end
      if (e == 3) begin
        data_addr = 12'd5;
        vga_addr  = 12'd131;
      end
      if (e == 4) begin
        check("fill_vga_live", vga_rv, 32'h00000099);
        check("fill_data_hold", data_rv, 32'hDEADBEEF);
      end
      if (e == 2000) begin
        data_addr = 12'd5; data_wv = 32'hFFFFFFFF; data_be = 4'b1111; data_we = 1'b1;
        fill_start = 1'b1;
      end
      if (e == 2001) begin
        data_we = 1'b0;
        fill_start = 1'b0;
      end
      if (e == DEPTH) fill_start = 1'b1;
      if (e == DEPTH + 1) fill_start = 1'b0;
      tick();
    end
    check("fill_busy_cycles", busy_cycles, DEPTH);
    check("fill_done_edge", done_edge, DEPTH);
    check("fill_done_pulses", done_pulses, 1);

    bad = 0;
    for (int a = 0; a < DEPTH; a++) begin
      data_addr = 12'(a);
      tick();
      if (data_rv !== 32'h00F00020) bad++;
    end
    check("fill_sweep_bad", bad, 0);

    // Reset mid-fill
    fill_value = 32'h12345678;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    repeat (100) tick();
    rst = 1'b1;
    #1;
    check("abort_busy_async", {31'b0, fill_busy}, 32'h0);
    check("abort_done", {31'b0, fill_done}, 32'h0);
    tick();
    rst = 1'b0;
    done_pulses = 0;
    repeat (10) begin
      tick();
      if (fill_done || fill_busy) done_pulses++;
    end
    check("abort_no_activity", done_pulses, 0);
    rd(12'd0);
    check("abort_cell0", data_rv, 32'h12345678);
    rd(12'd99);
    check("abort_cell99", data_rv, 32'h12345678);
    rd(12'd100);
    check("abort_cell100", data_rv, 32'h00F00020);
    rd(12'd4095);
    check("abort_cell4095", data_rv, 32'h00F00020);

    // Alternate parameters: 64x16, 16-bit cells
    a2_fv = 16'h0720;
    a2_fs = 1'b1;
    tick();
    a2_fs = 1'b0;
    busy_cycles = 0; done_edge = -1;
    for (int e = 0; e < DEPTH2 + 4; e++) begin
      if (a2_busy) busy_cycles++;
      if (a2_done && done_edge < 0) done_edge = e;
      tick();
    end
    check("alt_fill_busy_cycles", busy_cycles, DEPTH2);
    check("alt_fill_done_edge", done_edge, DEPTH2);
    a2_addr = 10'd69;
    tick();
    check("alt_fill_value", {16'h0, a2_rv}, 32'h00000720);
    a2_addr = 10'd5; a2_wv = 16'h4142; a2_be = 2'b11; a2_we = 1'b1;
    tick();
    a2_we = 1'b0;
    a2_vaddr = 10'd69; a2_scroll = 4'd15;
    tick();
    check("alt_scroll15", {16'h0, a2_vrv}, 32'h00004142);
    a2_scroll = 4'd0;
    tick();
    check("alt_scroll0", {16'h0, a2_vrv}, 32'h00000720);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
